// File: rtl/ps2_keyboard_receiver_if.sv
// PS/2 keyboard receiver bus: board pins in, decoded key and scan-code stream out.
`timescale 1ns/1ps
interface ps2_keyboard_receiver_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] character;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_error;

   modport master (
      output ps2_clk, ps2_data,
      input  character, scan_code, scan_valid, frame_error
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output character, scan_code, scan_valid, frame_error
   );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// Receive-only PS/2 keyboard front end: synchronise, deglitch ps2_clk, deframe
// 11-bit frames and track the currently held key from make/break codes.
`timescale 1ns/1ps
module ps2_keyboard_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ps2_keyboard_receiver_if.slave      bus
);

   localparam int FILT_W = $clog2(FILTER_LEN + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic              ps2_clk_p0, ps2_clk_p1;
   logic              ps2_data_p0, ps2_data_p1;
   logic              clk_filt, clk_filt_d;
   logic [FILT_W-1:0] filt_cnt;
   logic              strobe;

   state_t            state_q, state_d;
   logic [7:0]        shift_q;
   logic [2:0]        bit_cnt;
   logic              parity_q;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              tmo_hit;
   logic              frame_good, frame_bad;
   logic              brk_q, ext_q;

   // Stage p0/p1: two-flop synchronisers, then ps2_clk level filter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
         clk_filt    <= 1'b1;
         clk_filt_d  <= 1'b1;
         filt_cnt    <= '0;
      end else begin
         ps2_clk_p0  <= bus.ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_data_p0 <= bus.ps2_data;
         ps2_data_p1 <= ps2_data_p0;
         clk_filt_d  <= clk_filt;
         if (ps2_clk_p1 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
            clk_filt <= ps2_clk_p1;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
         end
      end
   end

   assign strobe  = clk_filt_d & ~clk_filt;
   assign tmo_hit = (state_q != IDLE) && !strobe &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Frame FSM: timeout takes priority, otherwise advance on strobes only
   always_comb begin
      state_d    = state_q;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      if (tmo_hit) begin
         state_d   = IDLE;
         frame_bad = 1'b1;
      end else if (strobe) begin
         case (state_q)
            IDLE:    if (!ps2_data_p1) state_d = DATA;
            DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
            PARITY:  state_d = STOP;
            STOP: begin
               state_d = IDLE;
               if (ps2_data_p1 && (^{shift_q, parity_q}))
                  frame_good = 1'b1;
               else
                  frame_bad = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bit_cnt  <= '0;
         parity_q <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (strobe || state_q == IDLE || tmo_hit)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         if (strobe && !tmo_hit) begin
            case (state_q)
               IDLE:   bit_cnt <= '0;
               DATA: begin
                  shift_q <= {ps2_data_p1, shift_q[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY: parity_q <= ps2_data_p1;
               default: ;
            endcase
         end
      end
   end

   // Stage out: publish byte and decode make/break/extended prefixes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.scan_code   <= '0;
         bus.scan_valid  <= 1'b0;
         bus.frame_error <= 1'b0;
         bus.character   <= '0;
         brk_q           <= 1'b0;
         ext_q           <= 1'b0;
      end else begin
         bus.scan_valid  <= frame_good;
         bus.frame_error <= frame_bad;
         if (frame_good) begin
            bus.scan_code <= shift_q;
            if (shift_q == 8'hE0) begin
               ext_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
               brk_q <= 1'b1;
            end else begin
               // Extended keys are not tracked; a released key only clears if it is the held one
               if (!ext_q) begin
                  if (brk_q) begin
                     if (shift_q == bus.character) bus.character <= 8'h00;
                  end else begin
                     bus.character <= shift_q;
                  end
               end
               ext_q <= 1'b0;
               brk_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver: framing, decode, errors, timeout, glitches, reset.
`timescale 1ns/1ps
module tb_ps2_keyboard_receiver;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 10000;
   // Compressed PS/2 bit period keeps the run short; the receiver is rate-agnostic below the timeout
   localparam int HALF = 100;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   sv_cnt;
   int   fe_cnt;

   ps2_keyboard_receiver_if bus();

   ps2_keyboard_receiver #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (bus.scan_valid === 1'b1)  sv_cnt <= sv_cnt + 1;
      if (bus.frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] b, input bit flip_par);
      return {1'b1, (~^b) ^ flip_par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] vec, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         bus.ps2_data = vec[i];
         if (glitch) begin
            wait_cyc(30); bus.ps2_clk = 1'b0; wait_cyc(3); bus.ps2_clk = 1'b1;
            wait_cyc(30); bus.ps2_clk = 1'b0; wait_cyc(3); bus.ps2_clk = 1'b1;
            wait_cyc(HALF - 66);
         end else begin
            wait_cyc(HALF);
         end
         bus.ps2_clk = 1'b0;
         wait_cyc(HALF);
         bus.ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
      send_bits(mkframe(b, flip_par), 11, glitch);
      bus.ps2_data = 1'b1;
      wait_cyc(40);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wait_cyc(5);
      @(negedge clk);
      checks++; if (bus.character !== 8'h00) begin errors++; $display("FAIL reset_character: got %h expected 00", bus.character); end
      checks++; if (bus.scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan_code: got %h expected 00", bus.scan_code); end
      checks++; if (bus.scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid: got %b expected 0", bus.scan_valid); end
      checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b expected 0", bus.frame_error); end
      rst_n = 1'b1;
      wait_cyc(20);
   endtask

   task automatic test_single_frame;
      int sv0, fe0;
      sv0 = sv_cnt; fe0 = fe_cnt;
      send_frame(8'h2D, 1'b0, 1'b0);
      checks++; if (sv_cnt - sv0 !== 1) begin errors++; $display("FAIL t1_valid_pulses: got %0d expected 1", sv_cnt - sv0); end
      checks++; if (bus.scan_code !== 8'h2D) begin errors++; $display("FAIL t1_scan_code: got %h expected 2d", bus.scan_code); end
      checks++; if (bus.character !== 8'h2D) begin errors++; $display("FAIL t1_character: got %h expected 2d", bus.character); end
      checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL t1_frame_error: got %0d expected 0", fe_cnt - fe0); end
   endtask

   task automatic test_make_break;
      int sv0;
      sv0 = sv_cnt;
      send_frame(8'h32, 1'b0, 1'b0);
      checks++; if (bus.character !== 8'h32) begin errors++; $display("FAIL t2_make: got %h expected 32", bus.character); end
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h32, 1'b0, 1'b0);
      checks++; if (bus.character !== 8'h00) begin errors++; $display("FAIL t2_break: got %h expected 00", bus.character); end
      checks++; if (sv_cnt - sv0 !== 3) begin errors++; $display("FAIL t2_valid_pulses: got %0d expected 3", sv_cnt - sv0); end
   endtask

   task automatic test_parity_error;
      int sv0, fe0;
      sv0 = sv_cnt; fe0 = fe_cnt;
      send_frame(8'h34, 1'b1, 1'b0);
      checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL t3_error_pulses: got %0d expected 1", fe_cnt - fe0); end
      checks++; if (sv_cnt - sv0 !== 0) begin errors++; $display("FAIL t3_no_valid: got %0d expected 0", sv_cnt - sv0); end
      checks++; if (bus.character !== 8'h00) begin errors++; $display("FAIL t3_char_kept: got %h expected 00", bus.character); end
      send_frame(8'h34, 1'b0, 1'b0);
      checks++; if (bus.character !== 8'h34) begin errors++; $display("FAIL t3_recover: got %h expected 34", bus.character); end
   endtask

   task automatic test_timeout;
      int fe0, sv0;
      fe0 = fe_cnt; sv0 = sv_cnt;
      send_bits(mkframe(8'h2D, 1'b0), 6, 1'b0);
      bus.ps2_data = 1'b1;
      wait_cyc(TIMEOUT_CYCLES + 10);
      @(negedge clk);
      checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL t4_timeout_error: got %0d expected 1", fe_cnt - fe0); end
      checks++; if (sv_cnt - sv0 !== 0) begin errors++; $display("FAIL t4_no_valid: got %0d expected 0", sv_cnt - sv0); end
      send_frame(8'h2D, 1'b0, 1'b0);
      checks++; if (bus.scan_code !== 8'h2D) begin errors++; $display("FAIL t4_scan_code: got %h expected 2d", bus.scan_code); end
      checks++; if (bus.character !== 8'h2D) begin errors++; $display("FAIL t4_character: got %h expected 2d", bus.character); end
   endtask

   task automatic test_glitch;
      int sv0, fe0;
      sv0 = sv_cnt; fe0 = fe_cnt;
      send_frame(8'h1C, 1'b0, 1'b1);
      checks++; if (sv_cnt - sv0 !== 1) begin errors++; $display("FAIL t5_valid_pulses: got %0d expected 1", sv_cnt - sv0); end
      checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL t5_frame_error: got %0d expected 0", fe_cnt - fe0); end
      checks++; if (bus.scan_code !== 8'h1C) begin errors++; $display("FAIL t5_scan_code: got %h expected 1c", bus.scan_code); end
      checks++; if (bus.character !== 8'h1C) begin errors++; $display("FAIL t5_character: got %h expected 1c", bus.character); end
   endtask

   task automatic test_hold_and_reset;
      int sv0;
      send_frame(8'h2D, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h32, 1'b0, 1'b0);
      checks++; if (bus.character !== 8'h2D) begin errors++; $display("FAIL t6_other_break: got %h expected 2d", bus.character); end
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      checks++; if (bus.character !== 8'h2D) begin errors++; $display("FAIL t6_extended: got %h expected 2d", bus.character); end
      checks++; if (bus.scan_code !== 8'h75) begin errors++; $display("FAIL t6_ext_scan_code: got %h expected 75", bus.scan_code); end
      send_bits(mkframe(8'h2D, 1'b0), 4, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.character !== 8'h00) begin errors++; $display("FAIL t6_rst_character: got %h expected 00", bus.character); end
      checks++; if (bus.scan_code !== 8'h00) begin errors++; $display("FAIL t6_rst_scan_code: got %h expected 00", bus.scan_code); end
      checks++; if (bus.scan_valid !== 1'b0 || bus.frame_error !== 1'b0) begin errors++; $display("FAIL t6_rst_pulses: got %b%b expected 00", bus.scan_valid, bus.frame_error); end
      bus.ps2_data = 1'b1;
      bus.ps2_clk  = 1'b1;
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(20);
      sv0 = sv_cnt;
      send_frame(8'h2D, 1'b0, 1'b0);
      checks++; if (sv_cnt - sv0 !== 1 || bus.character !== 8'h2D) begin errors++; $display("FAIL t6_after_reset: got %0d/%h expected 1/2d", sv_cnt - sv0, bus.character); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sv_cnt = 0;
      fe_cnt = 0;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      rst_n = 1'b0;
      test_reset();
      test_single_frame();
      test_make_break();
      test_parity_error();
      test_timeout();
      test_glitch();
      test_hold_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
